if_stage: RTL and testbench
===========================

// Module: if_stage
// PURPOSE
//  Instruction-fetch stage of the five-stage core. It owns the fetch PC and issues one-outstanding requests to instruction memory.
//  It drives the IF/ID pipeline register. It consumes the next-PC/flush pair from the PC-select logic and the stall from the hazard unit.
//  On flush it redirects to next_pc and kills wrong-path instructions, including any still in flight in memory.
// PARAMETERS
//  RESET_PC   32'h0000_0000  fetch PC loaded on reset
//  NOP_INSTR  32'h0000_0013  addi x0,x0,0; the bubble written into IF/ID
// PORTS
//  clk            in   1   core clock; all state updates on the rising edge
//  rst            in   1   synchronous, active-high reset
//  next_pc        in   32  redirect target; used only when flush=1
//  flush          in   1   redirect: load next_pc and kill in-flight and IF/ID contents
//  stall          in   1   hazard hold: freeze PC issue and IF/ID
//  imem_req       out  1   fetch request valid
//  imem_addr      out  32  fetch address, always equal to pc
//  imem_gnt       in   1   memory accepts the request this cycle (combinational)
//  imem_rvalid    in   1   response valid; earliest is the cycle after grant
//  imem_rdata     in   32  instruction word
//  pc             out  32  current fetch PC
//  if_id_valid    out  1   IF/ID holds a live instruction
//  if_id_pc       out  32  PC of the IF/ID instruction
//  if_id_pc_add_4 out  32  if_id_pc + 4 (mod 2^32)
//  if_id_instr    out  32  instruction, or NOP_INSTR when invalid
// BEHAVIOUR
//  Reset: pc=RESET_PC, state=FETCH, hold_valid=0, if_id_valid=0, if_id_pc=0, if_id_pc_add_4=4, if_id_instr=NOP_INSTR.
//    imem_req=0 while rst=1. An in-flight response that arrives after reset is ignored, because state is FETCH.
//  States: FETCH (may issue), WAIT (one outstanding), DRAIN (outstanding and killed), HOLD (response parked by stall).
//  imem_req = !rst && !flush && !stall && ((FETCH && !hold_valid) || (WAIT && imem_rvalid)).
//  Grant (imem_req && imem_gnt): pc <= pc+4 and state -> WAIT. The PC of the request is kept in req_pc.
//  WAIT with rvalid and no stall, flush or grant: deliver the response to IF/ID and go to FETCH.
//    With a grant in the same cycle, stay in WAIT. This gives back-to-back issue: 1 instr/cycle with single-cycle memory.
//  WAIT with rvalid and stall: park {req_pc, rdata} in the hold register (hold_valid=1) and go to HOLD. IF/ID is unchanged.
//  HOLD with stall=0: move the hold register into IF/ID, clear hold_valid, go to FETCH. No request is issued that cycle.
//  Flush has priority over stall and rvalid:
//    - pc <= next_pc; IF/ID <= bubble (valid=0, instr=NOP_INSTR); hold_valid <= 0.
//    - FETCH, HOLD, or WAIT with rvalid -> FETCH. WAIT without rvalid -> DRAIN. DRAIN stays DRAIN.
//    - A repeated flush in DRAIN only reloads pc.
//  DRAIN: request suppressed. On rvalid the data is discarded and state -> FETCH.
//  IF/ID when stall=0 and flush=0: the delivered instruction (valid=1) if any, else a bubble. When stall=1 and flush=0: hold.
//  Latency: a grant at cycle T with rvalid at T+1 gives if_id_valid=1 at T+2.
//  PC arithmetic is mod 2^32; 32'hFFFF_FFFC+4 wraps to 0. Bits [1:0] are passed through unchanged, with no misalignment check.
// STRUCTURE
//  Shared core header (core_defs.vh): NOP_INSTR, RESET_PC, and the fetch-state encodings FS_FETCH/FS_WAIT/FS_DRAIN/FS_HOLD (2 bits).
//  One sub-module, if_id_reg: the IF/ID register with synchronous reset, flush-to-bubble, stall-hold and load.
//  PC register, FSM and hold register stay in if_stage.
// TESTING
//  1. Reset then release; gnt=1 always; rvalid=1 one cycle after each grant.
//     -> if_id_pc = 0,4,8,... one per cycle from cycle 2; if_id_instr matches memory.
//  2. Flush in WAIT with no rvalid: next_pc=0x100, then rvalid with 0xDEADBEEF.
//     -> the word is discarded and never valid; the next request has imem_addr=0x100; IF/ID is a bubble for the whole drain.
//  3. stall=1 in the cycle rvalid arrives with word 0x00500093.
//     -> IF/ID is unchanged and no imem_req during the stall. Stall drops -> if_id_instr=0x00500093 next edge, then fetch resumes.
//  4. flush and stall together in HOLD, next_pc=0x40.
//     -> hold is cleared, if_id_valid=0, pc=0x40, and the next request is at 0x40 once stall drops.
//  5. gnt held 0 for 3 cycles.
//     -> imem_req stays 1 with a stable imem_addr, pc does not advance, and IF/ID gets bubbles.
//  6. pc=0xFFFF_FFFC granted. -> pc wraps to 0x0 and if_id_pc_add_4=0x0.
//     Also: rst asserted while in WAIT -> all outputs return to their reset values the next cycle.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared fetch-stage definitions: reset constants, fetch-state encoding and PC helper.
package if_stage_pkg;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

  typedef enum logic [1:0] {
    FS_FETCH = 2'd0,
    FS_WAIT  = 2'd1,
    FS_DRAIN = 2'd2,
    FS_HOLD  = 2'd3
  } fetch_state_t;

  function automatic logic [31:0] pc_inc(input logic [31:0] p);
    return p + 32'd4;
  endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: synchronous reset, flush-to-bubble, stall-hold, load.
module if_id_reg
  import if_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        stall,
  input  logic        load,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_instr,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] pc_add_4,
  output logic [31:0] instr
);

  // A bubble keeps the stale PC fields; only valid/instr mark it dead.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid    <= 1'b0;
      pc       <= 32'd0;
      pc_add_4 <= 32'd4;
      instr    <= NOP_INSTR;
    end else if (flush) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
    end else if (!stall) begin
      if (load) begin
        valid    <= 1'b1;
        pc       <= load_pc;
        pc_add_4 <= pc_inc(load_pc);
        instr    <= load_instr;
      end else begin
        valid <= 1'b0;
        instr <= NOP_INSTR;
      end
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: fetch PC, one-outstanding imem handshake, kill of
// wrong-path responses, stall parking and the IF/ID register.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] next_pc,
  input  logic        flush,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_add_4,
  output logic [31:0] if_id_instr
);

  fetch_state_t state_reg;
  logic [31:0]  pc_reg;
  logic [31:0]  req_pc_reg;
  logic [31:0]  hold_pc_reg;
  logic [31:0]  hold_instr_reg;
  logic         hold_valid_reg;

  logic         grant;
  logic         deliver_mem;
  logic         deliver_hold;
  logic         load;
  logic [31:0]  load_pc;
  logic [31:0]  load_instr;

  assign pc        = pc_reg;
  assign imem_addr = pc_reg;

  // Re-issue while the previous response lands gives one instruction per cycle.
  assign imem_req = !rst && !flush && !stall &&
                    (((state_reg == FS_FETCH) && !hold_valid_reg) ||
                     ((state_reg == FS_WAIT) && imem_rvalid));
  assign grant    = imem_req && imem_gnt;

  assign deliver_mem  = (state_reg == FS_WAIT) && imem_rvalid && !stall;
  assign deliver_hold = (state_reg == FS_HOLD) && !stall;
  assign load         = deliver_mem || deliver_hold;
  assign load_pc      = deliver_hold ? hold_pc_reg    : req_pc_reg;
  assign load_instr   = deliver_hold ? hold_instr_reg : imem_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= FS_FETCH;
      pc_reg         <= RESET_PC;
      req_pc_reg     <= 32'd0;
      hold_pc_reg    <= 32'd0;
      hold_instr_reg <= 32'd0;
      hold_valid_reg <= 1'b0;
    end else if (flush) begin
      pc_reg         <= next_pc;
      hold_valid_reg <= 1'b0;
      // An outstanding response must still be swallowed before fetching again.
      if (((state_reg == FS_WAIT) || (state_reg == FS_DRAIN)) && !imem_rvalid)
        state_reg <= FS_DRAIN;
      else
        state_reg <= FS_FETCH;
    end else begin
      if (grant) begin
        pc_reg     <= pc_inc(pc_reg);
        req_pc_reg <= pc_reg;
      end
      case (state_reg)
        FS_FETCH: begin
          if (grant) state_reg <= FS_WAIT;
        end
        FS_WAIT: begin
          if (imem_rvalid) begin
            if (stall) begin
              hold_pc_reg    <= req_pc_reg;
              hold_instr_reg <= imem_rdata;
              hold_valid_reg <= 1'b1;
              state_reg      <= FS_HOLD;
            end else if (!grant) begin
              state_reg <= FS_FETCH;
            end
          end
        end
        FS_DRAIN: begin
          if (imem_rvalid) state_reg <= FS_FETCH;
        end
        FS_HOLD: begin
          if (!stall) begin
            hold_valid_reg <= 1'b0;
            state_reg      <= FS_FETCH;
          end
        end
        default: state_reg <= FS_FETCH;
      endcase
    end
  end

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id_reg (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .stall     (stall),
    .load      (load),
    .load_pc   (load_pc),
    .load_instr(load_instr),
    .valid     (if_id_valid),
    .pc        (if_id_pc),
    .pc_add_4  (if_id_pc_add_4),
    .instr     (if_id_instr)
  );

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: memory responder with a granted-request scoreboard plus
// directed checks for latency, drain, stall parking, flush, grant back-off and wrap.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic [31:0] next_pc;
  logic        flush;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_add_4;
  logic [31:0] if_id_instr;

  if_stage dut (
    .clk           (clk),
    .rst           (rst),
    .next_pc       (next_pc),
    .flush         (flush),
    .stall         (stall),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .pc            (pc),
    .if_id_valid   (if_id_valid),
    .if_id_pc      (if_id_pc),
    .if_id_pc_add_4(if_id_pc_add_4),
    .if_id_instr   (if_id_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  int          resp_delay = 0;
  logic        force_en = 1'b0;
  logic [31:0] force_word = 32'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  // Memory responder and scoreboard: drive rvalid at the falling edge, sample
  // the handshake just before the rising edge.
  initial begin : responder
    logic        pend;
    logic [31:0] pend_word;
    int          pend_cnt;
    logic        stall_p, flush_p, rst_p;
    exp_t        e;
    pend = 1'b0; pend_word = 32'd0; pend_cnt = 0;
    stall_p = 1'b0; flush_p = 1'b0; rst_p = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'd0;
    forever begin
      @(negedge clk);
      if (rst_p || flush_p) begin
        check("bubble_after_kill", {31'd0, if_id_valid}, 32'd0);
      end else if (!stall_p && if_id_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", {31'd0, if_id_valid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          $display("fetch pc=%h instr=%h", if_id_pc, if_id_instr);
          check("sb_pc", if_id_pc, e.pc);
          check("sb_instr", if_id_instr, e.instr);
          check("sb_pc_add_4", if_id_pc_add_4, e.pc + 32'd4);
        end
      end
      if (!if_id_valid) check("bubble_nop", if_id_instr, NOP);

      if (pend && pend_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = pend_word;
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
      end

      #3;
      stall_p = stall;
      flush_p = flush;
      rst_p   = rst;
      if (rst || flush) exp_q.delete();
      if (imem_rvalid) pend = 1'b0;
      else if (pend && pend_cnt > 0) pend_cnt--;
      if (imem_req && imem_gnt) begin
        pend      = 1'b1;
        pend_word = force_en ? force_word : mem_word(imem_addr);
        pend_cnt  = resp_delay;
        exp_q.push_back('{pc: imem_addr, instr: pend_word});
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pc"}, pc, 32'h0);
    check({tag, "_req"}, {31'd0, imem_req}, 32'd0);
    check({tag, "_valid"}, {31'd0, if_id_valid}, 32'd0);
    check({tag, "_if_id_pc"}, if_id_pc, 32'h0);
    check({tag, "_add4"}, if_id_pc_add_4, 32'h4);
    check({tag, "_instr"}, if_id_instr, NOP);
  endtask

  initial begin : main
    logic [31:0] a0, snap_pc, snap_instr;
    rst = 1'b1; stall = 1'b0; flush = 1'b0; next_pc = 32'd0; imem_gnt = 1'b1;
    repeat (3) step();
    check_reset_outputs("reset");

    // Streaming: one instruction per cycle, first valid two edges after release.
    rst = 1'b0;
    step();
    step();
    check("latency_valid", {31'd0, if_id_valid}, 32'd1);
    check("latency_pc", if_id_pc, 32'h0);
    for (int k = 1; k <= 5; k++) begin
      step();
      check("stream_pc", if_id_pc, 32'(4 * k));
    end

    // Grant withheld for three cycles.
    imem_gnt = 1'b0;
    #1;
    a0 = imem_addr;
    check("nogrant_req0", {31'd0, imem_req}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("nogrant_req", {31'd0, imem_req}, 32'd1);
      check("nogrant_addr", imem_addr, a0);
      check("nogrant_pc", pc, a0);
      if (i > 0) check("nogrant_bubble", {31'd0, if_id_valid}, 32'd0);
    end

    // Flush in WAIT before the response: word must be drained, never valid.
    force_en = 1'b1; force_word = 32'hDEAD_BEEF; resp_delay = 3; imem_gnt = 1'b1;
    step();
    force_en = 1'b0;
    flush = 1'b1; next_pc = 32'h100;
    #1;
    check("flush_no_req", {31'd0, imem_req}, 32'd0);
    step();
    flush = 1'b0; resp_delay = 0;
    for (int i = 0; i < 10 && !imem_req; i++) begin
      check("drain_bubble", {31'd0, if_id_valid}, 32'd0);
      check("drain_pc", pc, 32'h100);
      step();
    end
    check("redirect_req", {31'd0, imem_req}, 32'd1);
    check("redirect_addr", imem_addr, 32'h100);
    repeat (3) step();

    // Stall in the cycle the response lands: parked, then delivered on release.
    force_en = 1'b1; force_word = 32'h0050_0093;
    step();
    force_en = 1'b0;
    stall = 1'b1;
    #1;
    check("stall_no_req0", {31'd0, imem_req}, 32'd0);
    snap_pc = if_id_pc; snap_instr = if_id_instr;
    check("stall_snap_valid", {31'd0, if_id_valid}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_hold_pc", if_id_pc, snap_pc);
      check("stall_hold_instr", if_id_instr, snap_instr);
      check("stall_no_req", {31'd0, imem_req}, 32'd0);
    end
    stall = 1'b0;
    #1;
    check("unpark_no_req", {31'd0, imem_req}, 32'd0);
    step();
    check("unpark_instr", if_id_instr, 32'h0050_0093);
    check("unpark_valid", {31'd0, if_id_valid}, 32'd1);
    check("resume_req", {31'd0, imem_req}, 32'd1);

    // Flush together with stall while in HOLD.
    step();
    stall = 1'b1;
    step();
    flush = 1'b1; next_pc = 32'h40;
    #1;
    check("hold_flush_no_req", {31'd0, imem_req}, 32'd0);
    step();
    flush = 1'b0;
    check("hold_flush_pc", pc, 32'h40);
    check("hold_flush_valid", {31'd0, if_id_valid}, 32'd0);
    step();
    check("hold_flush_valid2", {31'd0, if_id_valid}, 32'd0);
    check("hold_flush_no_req2", {31'd0, imem_req}, 32'd0);
    stall = 1'b0;
    #1;
    check("hold_flush_req", {31'd0, imem_req}, 32'd1);
    check("hold_flush_addr", imem_addr, 32'h40);

    // PC wrap at the top of the address space.
    flush = 1'b1; next_pc = 32'hFFFF_FFF8;
    step();
    flush = 1'b0;
    step();
    check("wrap_pc_fc", pc, 32'hFFFF_FFFC);
    step();
    check("wrap_pc_0", pc, 32'h0);
    step();
    check("wrap_if_id_pc", if_id_pc, 32'hFFFF_FFFC);
    check("wrap_add4", if_id_pc_add_4, 32'h0);

    // Reset asserted while a request is outstanding.
    resp_delay = 2;
    step();
    rst = 1'b1;
    step();
    check_reset_outputs("rst_in_wait");
    resp_delay = 0;
    repeat (4) step();
    check_reset_outputs("rst_held");
    rst = 1'b0;
    step();
    step();
    check("post_reset_pc", if_id_pc, 32'h0);
    check("post_reset_valid", {31'd0, if_id_valid}, 32'd1);
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
